bch_serial_encoder: RTL and testbench
=====================================

BCH_SERIAL_ENCODER -- requirements
Module: bch_serial_encoder

Interface
REQ-001 Parameter N, default 16200, codeword length in bits.
REQ-002 Parameter PAR, default 192, parity length in bits; K = N-PAR info bits.
REQ-003 Parameter GPOLY, PAR bits wide; default is the DVB-S2 t=12 generator g1·…·g12 (EN 302 307 Table 6a), coefficients x^(PAR-1)..x^0, x^PAR implicit.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 R  input  1  serial info bit, MSB (highest-degree) first.
REQ-007 R_valid  input  1  R is valid this cycle.
REQ-008 sof_in  input  1  qualifies first info bit of a frame; meaningful only with R_valid.
REQ-009 ready  output  1  encoder accepts R this cycle.
REQ-010 C1  output  1  serial codeword bit: K info bits, then PAR parity bits.
REQ-011 C1_valid  output  1  C1 valid this cycle.
REQ-012 sof_out / eof_out  output  1 each  mark first / last codeword bit.
REQ-013 abort  output  1  one-cycle pulse when a frame is dropped per REQ-021.

Function
REQ-014 States IDLE, INFO, PARITY; transfer = R_valid & ready.
REQ-015 ready = 1 in IDLE and INFO, 0 in PARITY.
REQ-016 IDLE: transfer with sof_in=1 -> INFO, info counter = 1; transfer with sof_in=0 is discarded, no output.
REQ-017 Each accepted info bit: fb = R ^ lfsr[PAR-1]; lfsr <= {lfsr[PAR-2:0],0} ^ (fb ? GPOLY : 0); lfsr cleared at the sof transfer before its update.
REQ-018 Each accepted info bit appears on C1 with C1_valid=1 exactly 1 cycle later (registered); sof_out=1 on the first.
REQ-019 After the K-th info bit -> PARITY; next PAR cycles emit lfsr MSB first, shifting left with zero fill, C1_valid=1 every cycle, eof_out=1 on the last; then -> IDLE.
REQ-020 R_valid gaps in INFO allowed; C1_valid=0 during gaps; no gaps in PARITY.
REQ-021 sof_in=1 transfer in INFO before K bits: abort pulses, frame restarts with this bit as bit 1; already-emitted bits are not retracted.
REQ-022 Back-to-back: sof_in accepted the cycle after PARITY's last emission cycle (state IDLE, ready=1); no bubble beyond that.
REQ-023 Info counter width ceil(log2(N+1)); parity counter ceil(log2(PAR+1)); no wrap within a frame.

Reset
REQ-024 reset=1 at a clock edge: state IDLE, lfsr=0, counters=0, C1=0, C1_valid=0, sof_out=0, eof_out=0, abort=0; ready=1 in the following cycle.
REQ-025 Reset mid-frame drops the frame with no eof_out and no abort; reset dominates all inputs that cycle.

Configuration
REQ-026 Macro BCH_ENC_FRAME_CNT_EN defined: extra output frame_cnt (16-bit) increments on each eof_out, wraps 0xFFFF->0, resets to 0.
REQ-027 Macro undefined: frame_cnt port and counter absent; all other behaviour identical.

Verification
REQ-028 Defaults, K zeros with sof on first -> 16200 C1_valid bits all 0, sof_out on bit 1, eof_out on bit 16200.
REQ-029 Defaults, info all zero except last info bit = 1 -> 192 parity bits equal GPOLY, MSB first.
REQ-030 N=24, PAR=8, GPOLY=8'h1D, 16 info bits 0xA5C3 with R_valid toggling 1/0 -> output equals software-model codeword, info bits 1 cycle after each accept, parity contiguous.
REQ-031 Defaults, sof_in again at info bit 500 -> abort pulse, new frame completes correctly, exactly one eof_out.
REQ-032 Reset asserted in PARITY cycle 10 -> next cycle all outputs 0, ready=1; fresh frame encodes correctly.
REQ-033 BCH_ENC_FRAME_CNT_EN defined, 3 back-to-back frames -> frame_cnt 1,2,3 after each eof_out, no idle cycles between frames.

Source files
------------

// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH encoder: K info bits pass through, then PAR LFSR parity bits.
// Define BCH_ENC_FRAME_CNT_EN to add the 16-bit frame_cnt output.

// DVB-S2 t=12 generator: product of g1..g12 over GF(2), x^192 term dropped.
function automatic logic [191:0] bch_dvbs2_t12_gpoly();
    logic [11:0][16:0] g;
    logic [192:0]      prod;
    logic [192:0]      acc;
    g[0]  = 17'h1002D;
    g[1]  = 17'h10173;
    g[2]  = 17'h10FBD;
    g[3]  = 17'h15A55;
    g[4]  = 17'h11F2F;
    g[5]  = 17'h1F7B5;
    g[6]  = 17'h1AF65;
    g[7]  = 17'h17367;
    g[8]  = 17'h10EA1;
    g[9]  = 17'h175A7;
    g[10] = 17'h13A2D;
    g[11] = 17'h11AE3;
    prod  = 193'd1;
    for (int i = 0; i < 12; i++) begin
        acc = '0;
        for (int j = 0; j < 17; j++) begin
            if (g[i][j]) acc = acc ^ (prod << j);
        end
        prod = acc;
    end
    return prod[191:0];
endfunction

module bch_serial_encoder #(
    parameter int unsigned    N     = 16200,
    parameter int unsigned    PAR   = 192,
    parameter logic [PAR-1:0] GPOLY = PAR'(bch_dvbs2_t12_gpoly())
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        R,
    input  logic        R_valid,
    input  logic        sof_in,
    output logic        ready,
    output logic        C1,
    output logic        C1_valid,
    output logic        sof_out,
    output logic        eof_out,
    output logic        abort
`ifdef BCH_ENC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned    K       = N - PAR;
    localparam int unsigned    ICW     = $clog2(N + 1);
    localparam int unsigned    PCW     = $clog2(PAR + 1);
    localparam logic [ICW-1:0] KLast   = ICW'(K - 1);
    localparam logic [PCW-1:0] ParLast = PCW'(PAR - 1);

    typedef enum logic [1:0] {StIdle, StInfo, StParity} state_e;

    state_e         state;
    logic [PAR-1:0] lfsr;
    logic [PAR-1:0] lfsr_base;
    logic [PAR-1:0] lfsr_step;
    logic [ICW-1:0] info_cnt;
    logic [PCW-1:0] par_cnt;
    logic           xfer;
    logic           fb;

    assign ready = (state != StParity);
    assign xfer  = R_valid & ready;

    // A sof transfer starts the division from an empty remainder.
    always_comb begin
        lfsr_base = sof_in ? '0 : lfsr;
        fb        = R ^ lfsr_base[PAR-1];
        lfsr_step = {lfsr_base[PAR-2:0], 1'b0} ^ (fb ? GPOLY : '0);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= StIdle;
            lfsr     <= '0;
            info_cnt <= '0;
            par_cnt  <= '0;
            C1       <= 1'b0;
            C1_valid <= 1'b0;
            sof_out  <= 1'b0;
            eof_out  <= 1'b0;
            abort    <= 1'b0;
        end else begin
            C1_valid <= 1'b0;
            sof_out  <= 1'b0;
            eof_out  <= 1'b0;
            abort    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (xfer && sof_in) begin
                        lfsr     <= lfsr_step;
                        C1       <= R;
                        C1_valid <= 1'b1;
                        sof_out  <= 1'b1;
                        info_cnt <= ICW'(1);
                        state    <= StInfo;
                    end
                end
                StInfo: begin
                    if (xfer) begin
                        lfsr     <= lfsr_step;
                        C1       <= R;
                        C1_valid <= 1'b1;
                        if (sof_in) begin
                            // Restart: this bit becomes bit 1 of a new frame.
                            abort    <= 1'b1;
                            sof_out  <= 1'b1;
                            info_cnt <= ICW'(1);
                        end else if (info_cnt == KLast) begin
                            info_cnt <= '0;
                            par_cnt  <= '0;
                            state    <= StParity;
                        end else begin
                            info_cnt <= info_cnt + 1'b1;
                        end
                    end
                end
                StParity: begin
                    C1       <= lfsr[PAR-1];
                    C1_valid <= 1'b1;
                    lfsr     <= {lfsr[PAR-2:0], 1'b0};
                    if (par_cnt == ParLast) begin
                        par_cnt <= '0;
                        eof_out <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        par_cnt <= par_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef BCH_ENC_FRAME_CNT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (state == StParity && par_cnt == ParLast) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Bench for bch_serial_encoder: default-size and small (N=24) instances checked against a
// long-division polynomial model; frame_cnt checks apply when BCH_ENC_FRAME_CNT_EN is defined.

module tb_bch_serial_encoder;

    localparam int BN = 16200;
    localparam int BP = 192;
    localparam int BK = BN - BP;
    localparam int SK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic b_rst, b_r, b_rv, b_sof, b_ready, b_c1, b_c1v, b_sofo, b_eofo, b_abort;
    logic s_rst, s_r, s_rv, s_sof, s_ready, s_c1, s_c1v, s_sofo, s_eofo, s_abort;
`ifdef BCH_ENC_FRAME_CNT_EN
    logic [15:0] b_fcnt, s_fcnt;
    logic [15:0] s_fcnt_eof[$];
`endif

    bch_serial_encoder u_big (
        .CLK      (clk),
        .reset    (b_rst),
        .R        (b_r),
        .R_valid  (b_rv),
        .sof_in   (b_sof),
        .ready    (b_ready),
        .C1       (b_c1),
        .C1_valid (b_c1v),
        .sof_out  (b_sofo),
        .eof_out  (b_eofo),
        .abort    (b_abort)
`ifdef BCH_ENC_FRAME_CNT_EN
        ,
        .frame_cnt(b_fcnt)
`endif
    );

    bch_serial_encoder #(.N(24), .PAR(8), .GPOLY(8'h1D)) u_small (
        .CLK      (clk),
        .reset    (s_rst),
        .R        (s_r),
        .R_valid  (s_rv),
        .sof_in   (s_sof),
        .ready    (s_ready),
        .C1       (s_c1),
        .C1_valid (s_c1v),
        .sof_out  (s_sofo),
        .eof_out  (s_eofo),
        .abort    (s_abort)
`ifdef BCH_ENC_FRAME_CNT_EN
        ,
        .frame_cnt(s_fcnt)
`endif
    );

    // Output capture: every valid bit with its timestamp and frame-marker positions.
    bit    b_bits[$], s_bits[$];
    longint b_t[$], s_t[$];
    int    b_sofpos[$], s_sofpos[$], b_eofpos[$], s_eofpos[$];
    int    b_eof_n = 0, s_eof_n = 0, b_abort_n = 0, s_abort_n = 0;

    always @(negedge clk) begin
        if (b_c1v) begin
            if (b_sofo) b_sofpos.push_back(b_bits.size());
            if (b_eofo) b_eofpos.push_back(b_bits.size());
            b_bits.push_back(b_c1);
            b_t.push_back($time);
        end
        if (b_eofo) b_eof_n++;
        if (b_abort) b_abort_n++;
    end

    always @(negedge clk) begin
        if (s_c1v) begin
            if (s_sofo) s_sofpos.push_back(s_bits.size());
            if (s_eofo) s_eofpos.push_back(s_bits.size());
            s_bits.push_back(s_c1);
            s_t.push_back($time);
        end
        if (s_eofo) begin
            s_eof_n++;
`ifdef BCH_ENC_FRAME_CNT_EN
            s_fcnt_eof.push_back(s_fcnt);
`endif
        end
        if (s_abort) s_abort_n++;
    end

    bit gb[$];
    bit gs[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of info(x)*x^p divided by g(x); g given highest degree first.
    function automatic void model_parity(input bit info[$], input bit g[$], output bit par[$]);
        bit r[$];
        int p = g.size() - 1;
        r = info;
        repeat (p) r.push_back(1'b0);
        for (int i = 0; i < info.size(); i++) begin
            if (r[i]) begin
                for (int j = 0; j <= p; j++) r[i+j] = r[i+j] ^ g[j];
            end
        end
        par = {};
        for (int i = 0; i < p; i++) par.push_back(r[info.size()+i]);
    endfunction

    // Product of the twelve minimal polynomials, as a 193-entry coefficient list.
    function automatic void build_big_gen(output bit g[$]);
        bit prod[0:192];
        bit nxt[0:192];
        int ex[$];
        int deg = 0;
        foreach (prod[d]) prod[d] = 1'b0;
        prod[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:  ex = {16, 5, 3, 2, 0};
                1:  ex = {16, 8, 6, 5, 4, 1, 0};
                2:  ex = {16, 11, 10, 9, 8, 7, 5, 4, 3, 2, 0};
                3:  ex = {16, 14, 12, 11, 9, 6, 4, 2, 0};
                4:  ex = {16, 12, 11, 10, 9, 8, 5, 3, 2, 1, 0};
                5:  ex = {16, 15, 14, 13, 12, 10, 9, 8, 7, 5, 4, 2, 0};
                6:  ex = {16, 15, 13, 11, 10, 9, 8, 6, 5, 2, 0};
                7:  ex = {16, 14, 13, 12, 9, 8, 6, 5, 2, 1, 0};
                8:  ex = {16, 11, 10, 9, 7, 5, 0};
                9:  ex = {16, 14, 13, 12, 10, 8, 7, 5, 2, 1, 0};
                10: ex = {16, 13, 12, 11, 9, 5, 3, 2, 0};
                default: ex = {16, 12, 11, 9, 7, 6, 5, 1, 0};
            endcase
            foreach (nxt[d]) nxt[d] = 1'b0;
            foreach (ex[e]) begin
                for (int d = 0; d <= deg; d++) begin
                    if (prod[d]) nxt[d+ex[e]] = ~nxt[d+ex[e]];
                end
            end
            deg += 16;
            prod = nxt;
        end
        g = {};
        for (int d = 192; d >= 0; d--) g.push_back(prod[d]);
    endfunction

    task automatic send_bit(input bit big, input bit r, input bit sof);
        int n = 0;
        while (!(big ? b_ready : s_ready)) begin
            if (n++ > 1000) begin
                check("ready_wait", big ? b_ready : s_ready, 1);
                return;
            end
            @(posedge clk); #1;
        end
        if (big) begin b_r = r; b_rv = 1'b1; b_sof = sof; end
        else     begin s_r = r; s_rv = 1'b1; s_sof = sof; end
        @(posedge clk); #1;
        if (big) begin b_rv = 1'b0; b_sof = 1'b0; end
        else     begin s_rv = 1'b0; s_sof = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_eof(input bit big, input int target, input int budget);
        int n = 0;
        while ((big ? b_eof_n : s_eof_n) < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(big ? "big_eof_wait" : "small_eof_wait", big ? b_eof_n : s_eof_n, target);
    endtask

    task automatic send_frame(input bit big, input bit info[$], input int max_gap);
        foreach (info[i]) begin
            send_bit(big, info[i], i == 0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_frame(input bit big, input string tag, input bit info[$],
                               input int start);
        bit g[$], par[$], expq[$], got[$];
        longint t[$];
        int sp[$], ep[$];
        int mism = 0, gaps = 0, n;
        bit sof_ok = 1'b0, eof_ok = 1'b0;
        if (big) begin g = gb; got = b_bits; t = b_t; sp = b_sofpos; ep = b_eofpos; end
        else     begin g = gs; got = s_bits; t = s_t; sp = s_sofpos; ep = s_eofpos; end
        model_parity(info, g, par);
        expq = info;
        foreach (par[i]) expq.push_back(par[i]);
        n = expq.size();
        for (int i = 0; i < n; i++) begin
            if (start + i >= got.size() || got[start+i] !== expq[i]) mism++;
        end
        for (int i = start + info.size() - 1; i < start + n - 1; i++) begin
            if (i + 1 >= t.size() || t[i+1] - t[i] != 10) gaps++;
        end
        foreach (sp[i]) if (sp[i] == start) sof_ok = 1'b1;
        foreach (ep[i]) if (ep[i] == start + n - 1) eof_ok = 1'b1;
        check({tag, "_bits"}, mism, 0);
        check({tag, "_parity_contig"}, gaps, 0);
        check({tag, "_sof"}, sof_ok, 1);
        check({tag, "_eof"}, eof_ok, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit info[$], info2[$];
        bit par[$];
        int start, eb, ab, mism, ones;
        logic [15:0] word;

        b_rst = 1'b1; b_r = 1'b0; b_rv = 1'b0; b_sof = 1'b0;
        s_rst = 1'b1; s_r = 1'b0; s_rv = 1'b0; s_sof = 1'b0;
        build_big_gen(gb);
        gs = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0; s_rst = 1'b0;

        // Reset state.
        check("rst_ready", b_ready, 1);
        check("rst_c1", b_c1, 0);
        check("rst_c1_valid", b_c1v, 0);
        check("rst_sof_out", b_sofo, 0);
        check("rst_eof_out", b_eofo, 0);
        check("rst_abort", b_abort, 0);
        check("rst_small_ready", s_ready, 1);
        check("rst_small_c1_valid", s_c1v, 0);

        // Non-sof transfers in IDLE are discarded.
        start = s_bits.size();
        repeat (5) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        idle(2);
        check("idle_discard", s_bits.size() - start, 0);

        // 0xA5C3 with R_valid toggling; each bit visible one cycle after accept.
        begin
            int late = 0, gapv = 0;
            word = 16'hA5C3;
            info = {};
            for (int i = 15; i >= 0; i--) info.push_back(word[i]);
            start = s_bits.size();
            foreach (info[i]) begin
                send_bit(1'b0, info[i], i == 0);
                if (s_c1v !== 1'b1 || s_c1 !== info[i]) late++;
                if (i < SK - 1) begin
                    idle(1);
                    if (s_c1v !== 1'b0) gapv++;
                end
            end
            wait_eof(1'b0, 1, 100);
            check("a5c3_latency", late, 0);
            check("a5c3_gap_valid", gapv, 0);
            check_frame(1'b0, "a5c3", info, start);
        end

        // Three back-to-back random frames: output stream fully contiguous.
        begin
            bit fr[3][$];
            int gaps = 0;
            start = s_bits.size();
            for (int f = 0; f < 3; f++) begin
                fr[f] = {};
                repeat (SK) fr[f].push_back(1'($urandom_range(0, 1)));
                send_frame(1'b0, fr[f], 0);
            end
            wait_eof(1'b0, 4, 200);
            for (int f = 0; f < 3; f++) check_frame(1'b0, $sformatf("b2b%0d", f), fr[f], start + 24 * f);
            for (int i = start; i < start + 71; i++) begin
                if (i + 1 >= s_t.size() || s_t[i+1] - s_t[i] != 10) gaps++;
            end
            check("b2b_no_bubble", gaps, 0);
        end

        // Random frames with random R_valid gaps.
        for (int f = 0; f < 4; f++) begin
            info = {};
            repeat (SK) info.push_back(1'($urandom_range(0, 1)));
            start = s_bits.size();
            send_frame(1'b0, info, 2);
            wait_eof(1'b0, 5 + f, 200);
            check_frame(1'b0, $sformatf("rnd%0d", f), info, start);
        end
        check("small_no_abort", s_abort_n, 0);

`ifdef BCH_ENC_FRAME_CNT_EN
        foreach (s_fcnt_eof[k]) check($sformatf("frame_cnt%0d", k), s_fcnt_eof[k], k + 1);
        check("frame_cnt_entries", s_fcnt_eof.size(), 8);
`endif

        // Default size, all-zero info: all-zero codeword.
        info = {};
        repeat (BK) info.push_back(1'b0);
        start = b_bits.size();
        send_frame(1'b1, info, 0);
        wait_eof(1'b1, 1, 2000);
        ones = 0;
        for (int i = start; i < start + BN && i < b_bits.size(); i++) if (b_bits[i]) ones++;
        check("zeros_len", b_bits.size() - start, BN);
        check("zeros_ones", ones, 0);
        check_frame(1'b1, "zeros", info, start);

        // Restart at info bit 500: abort, then the new frame completes.
        eb = b_eof_n;
        ab = b_abort_n;
        info = {};
        repeat (499) info.push_back(1'($urandom_range(0, 1)));
        info2 = {};
        repeat (BK) info2.push_back(1'($urandom_range(0, 1)));
        start = b_bits.size() + 499;
        send_frame(1'b1, info, 0);
        send_frame(1'b1, info2, 0);
        wait_eof(1'b1, eb + 1, 2000);
        idle(20);
        check("restart_abort", b_abort_n - ab, 1);
        check("restart_one_eof", b_eof_n - eb, 1);
        check_frame(1'b1, "restart", info2, start);

        // Reset during parity cycle 10.
        eb = b_eof_n;
        ab = b_abort_n;
        info = {};
        repeat (BK) info.push_back(1'($urandom_range(0, 1)));
        send_frame(1'b1, info, 0);
        idle(9);
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        check("midrst_c1", b_c1, 0);
        check("midrst_c1_valid", b_c1v, 0);
        check("midrst_sof_out", b_sofo, 0);
        check("midrst_eof_out", b_eofo, 0);
        check("midrst_abort", b_abort, 0);
        check("midrst_ready", b_ready, 1);
        idle(300);
        check("midrst_no_eof", b_eof_n - eb, 0);
        check("midrst_no_abort", b_abort_n - ab, 0);

        // Fresh frame after reset: single 1 in the last info bit, parity equals GPOLY.
        info = {};
        repeat (BK - 1) info.push_back(1'b0);
        info.push_back(1'b1);
        start = b_bits.size();
        send_frame(1'b1, info, 0);
        wait_eof(1'b1, eb + 1, 2000);
        check_frame(1'b1, "gpoly", info, start);
        mism = 0;
        for (int i = 0; i < BP; i++) begin
            if (start + BK + i >= b_bits.size() || b_bits[start+BK+i] !== gb[i+1]) mism++;
        end
        check("gpoly_parity", mism, 0);
        model_parity(info, gb, par);
        mism = 0;
        for (int i = 0; i < BP; i++) if (par[i] !== gb[i+1]) mism++;
        check("gpoly_model", mism, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
